// File: rtl/ex_stage.sv
// Execute stage: condition check, barrel shifter, ALU with NZCV flags, and an
// iterative shift-add multiplier that stalls the front end while it runs.
module ex_stage #(
    parameter logic [4:0] MUL_OPCODE = 5'b10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [4:0]  opcode_in,
    input  logic [3:0]  cond_in,
    input  logic [31:0] read_data1_in,
    input  logic [31:0] read_data2_in,
    input  logic [10:0] imm_in,
    input  logic [3:0]  Rd_in,
    input  logic [1:0]  shift_type_in,
    input  logic [4:0]  shift_amt_in,
    input  logic        set_flags_in,
    input  logic        reg_write_en_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic        mem_to_reg_in,
    input  logic        branch_taken_in,
    input  logic        alu_src_in,
    input  logic [3:0]  alu_op_in,
    input  logic        alu_invert_rm_in,
    input  logic [31:0] branch_target_addr_in,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [3:0]  Rd_out,
    output logic [31:0] pc_out,
    output logic [31:0] branch_target_addr_out,
    output logic        reg_write_en_out,
    output logic        mem_read_en_out,
    output logic        mem_write_en_out,
    output logic        mem_to_reg_out,
    output logic        branch_taken_out,
    output logic [3:0]  flags_out,
    output logic        stall_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // ARM condition evaluation against {N,Z,C,V}; 4'b1111 never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    logic [3:0]  flags_r;
    logic [0:0]  state_r;
    logic [4:0]  count_r;
    logic [31:0] mcand_r, mplier_r, prod_r;
    logic [31:0] mul_pc_r, mul_bt_r, mul_store_r;
    logic [3:0]  mul_rd_r;
    logic        mul_we_r, mul_mr_r, mul_mw_r, mul_m2r_r, mul_br_r, mul_sf_r;

    logic        cond_ok_s, is_mul_s, mul_start_s, mul_done_s, is_cmp_s;
    logic [32:0] shl_s, lsr_s;
    logic signed [32:0] asr_in_s, asr_s;
    logic [31:0] ror_s, sh_res_s, op2_sel_s, op2_s, logic_res_s, alu_res_s, prod_next_s;
    logic        sh_carry_s, op2_carry_s, is_arith_s, op_valid_s, alu_flag_upd_s, ovf_s;
    logic [31:0] add_x_s, add_y_s;
    logic        add_cin_s;
    logic [32:0] sum_s;

    assign cond_ok_s   = cond_pass(cond_in, flags_r);
    assign is_mul_s    = (opcode_in == MUL_OPCODE);
    assign mul_start_s = (state_r == ST_IDLE) && is_mul_s && cond_ok_s;
    assign mul_done_s  = (state_r == ST_BUSY) && (count_r == 5'd31);
    assign stall_out   = reset && (mul_start_s || ((state_r == ST_BUSY) && !mul_done_s));
    assign flags_out   = flags_r;
    assign is_cmp_s    = (alu_op_in >= 4'h9) && (alu_op_in <= 4'hC);

    // Shift candidates carry an extra bit so the last bit shifted out is the carry.
    assign shl_s    = {1'b0, read_data2_in} << shift_amt_in;
    assign lsr_s    = {read_data2_in, 1'b0} >> shift_amt_in;
    assign asr_in_s = {read_data2_in, 1'b0};
    assign asr_s    = asr_in_s >>> shift_amt_in;
    assign ror_s    = (read_data2_in >> shift_amt_in) | (read_data2_in << (5'd0 - shift_amt_in));

    // Barrel shifter select; zero distance is the identity and keeps C.
    always_comb begin
        sh_res_s   = read_data2_in;
        sh_carry_s = flags_r[1];
        if (shift_amt_in == 5'd0) begin
            sh_res_s   = read_data2_in;
            sh_carry_s = flags_r[1];
        end else begin
            case (shift_type_in)
                2'b00:   begin sh_res_s = shl_s[31:0]; sh_carry_s = shl_s[32]; end
                2'b01:   begin sh_res_s = lsr_s[32:1]; sh_carry_s = lsr_s[0];  end
                2'b10:   begin sh_res_s = asr_s[32:1]; sh_carry_s = asr_s[0];  end
                default: begin sh_res_s = ror_s;       sh_carry_s = ror_s[31]; end
            endcase
        end
    end

    assign op2_sel_s   = alu_src_in ? {21'd0, imm_in} : sh_res_s;
    assign op2_carry_s = alu_src_in ? flags_r[1] : sh_carry_s;
    assign op2_s       = alu_invert_rm_in ? ~op2_sel_s : op2_sel_s;

    // ALU operand routing: every arithmetic op is an add of x, y and a carry-in.
    always_comb begin
        add_x_s     = read_data1_in;
        add_y_s     = op2_s;
        add_cin_s   = 1'b0;
        is_arith_s  = 1'b0;
        op_valid_s  = 1'b1;
        logic_res_s = 32'd0;
        case (alu_op_in)
            4'h0, 4'hB: logic_res_s = read_data1_in & op2_s;
            4'h1:       logic_res_s = read_data1_in | op2_s;
            4'h2, 4'hC: logic_res_s = read_data1_in ^ op2_s;
            4'h3, 4'hA: is_arith_s = 1'b1;
            4'h4, 4'h9: begin is_arith_s = 1'b1; add_y_s = ~op2_s; add_cin_s = 1'b1; end
            4'h5:       begin is_arith_s = 1'b1; add_x_s = op2_s; add_y_s = ~read_data1_in; add_cin_s = 1'b1; end
            4'h6:       begin is_arith_s = 1'b1; add_cin_s = flags_r[1]; end
            4'h7:       begin is_arith_s = 1'b1; add_y_s = ~op2_s; add_cin_s = flags_r[1]; end
            4'h8:       logic_res_s = op2_s;
            default:    op_valid_s = 1'b0;
        endcase
    end

    assign sum_s          = {1'b0, add_x_s} + {1'b0, add_y_s} + {32'd0, add_cin_s};
    assign ovf_s          = (add_x_s[31] == add_y_s[31]) && (sum_s[31] != add_x_s[31]);
    assign alu_res_s      = is_arith_s ? sum_s[31:0] : logic_res_s;
    assign alu_flag_upd_s = (state_r == ST_IDLE) && !is_mul_s && cond_ok_s &&
                            (set_flags_in || is_cmp_s) && op_valid_s;
    assign prod_next_s    = prod_r + (mplier_r[0] ? mcand_r : 32'd0);

    // Multiplier FSM: latch operands and the instruction's context, then 32 shift-add steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;  count_r <= 5'd0;
            mcand_r <= 32'd0;    mplier_r <= 32'd0; prod_r <= 32'd0;
            mul_pc_r <= 32'd0;   mul_bt_r <= 32'd0; mul_store_r <= 32'd0; mul_rd_r <= 4'd0;
            mul_we_r <= 1'b0;    mul_mr_r <= 1'b0;  mul_mw_r <= 1'b0;
            mul_m2r_r <= 1'b0;   mul_br_r <= 1'b0;  mul_sf_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mul_start_s) begin
                        state_r <= ST_BUSY;  count_r <= 5'd0;
                        mcand_r <= read_data1_in; mplier_r <= read_data2_in; prod_r <= 32'd0;
                        mul_pc_r <= pc_in;   mul_bt_r <= branch_target_addr_in;
                        mul_store_r <= read_data2_in; mul_rd_r <= Rd_in;
                        mul_we_r <= reg_write_en_in; mul_mr_r <= mem_read_en_in;
                        mul_mw_r <= mem_write_en_in; mul_m2r_r <= mem_to_reg_in;
                        mul_br_r <= branch_taken_in; mul_sf_r <= set_flags_in;
                    end
                end
                ST_BUSY: begin
                    prod_r   <= prod_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + 5'd1;
                    if (mul_done_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // NZCV register: MUL touches only N/Z, ALU ops follow the arithmetic/logical carry rules.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= 4'b0000;
        end else if (mul_done_s) begin
            if (mul_sf_r) begin
                flags_r <= {prod_next_s[31], (prod_next_s == 32'd0), flags_r[1:0]};
            end
        end else if (alu_flag_upd_s) begin
            flags_r <= {alu_res_s[31], (alu_res_s == 32'd0),
                        is_arith_s ? sum_s[32] : op2_carry_s,
                        is_arith_s ? ovf_s : flags_r[0]};
        end
    end

    // EX/MEM register: MUL completion, bubble while stalled, or the current instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_out <= 32'd0; store_data_out <= 32'd0; Rd_out <= 4'd0;
            pc_out <= 32'd0; branch_target_addr_out <= 32'd0;
            reg_write_en_out <= 1'b0; mem_read_en_out <= 1'b0; mem_write_en_out <= 1'b0;
            mem_to_reg_out <= 1'b0; branch_taken_out <= 1'b0;
        end else if (mul_done_s) begin
            alu_result_out <= prod_next_s; store_data_out <= mul_store_r; Rd_out <= mul_rd_r;
            pc_out <= mul_pc_r; branch_target_addr_out <= mul_bt_r;
            reg_write_en_out <= mul_we_r; mem_read_en_out <= mul_mr_r; mem_write_en_out <= mul_mw_r;
            mem_to_reg_out <= mul_m2r_r; branch_taken_out <= mul_br_r;
        end else if (stall_out) begin
            reg_write_en_out <= 1'b0; mem_read_en_out <= 1'b0; mem_write_en_out <= 1'b0;
            mem_to_reg_out <= 1'b0; branch_taken_out <= 1'b0;
        end else begin
            alu_result_out <= alu_res_s; store_data_out <= read_data2_in; Rd_out <= Rd_in;
            pc_out <= pc_in; branch_target_addr_out <= branch_target_addr_in;
            reg_write_en_out <= cond_ok_s && reg_write_en_in && !is_cmp_s;
            mem_read_en_out  <= cond_ok_s && mem_read_en_in;
            mem_write_en_out <= cond_ok_s && mem_write_en_in;
            mem_to_reg_out   <= cond_ok_s && mem_to_reg_in;
            branch_taken_out <= cond_ok_s && branch_taken_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU/shifter/condition vectors, MUL timing and reset abort.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, read_data1_in, read_data2_in, branch_target_addr_in;
    logic [4:0]  opcode_in, shift_amt_in;
    logic [3:0]  cond_in, Rd_in, alu_op_in;
    logic [10:0] imm_in;
    logic [1:0]  shift_type_in;
    logic        set_flags_in, reg_write_en_in, mem_read_en_in, mem_write_en_in;
    logic        mem_to_reg_in, branch_taken_in, alu_src_in, alu_invert_rm_in;
    logic [31:0] alu_result_out, store_data_out, pc_out, branch_target_addr_out;
    logic [3:0]  Rd_out, flags_out;
    logic        reg_write_en_out, mem_read_en_out, mem_write_en_out, mem_to_reg_out;
    logic        branch_taken_out, stall_out;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt, bubbles, guard, bad_cycles;

    ex_stage dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .opcode_in(opcode_in), .cond_in(cond_in),
        .read_data1_in(read_data1_in), .read_data2_in(read_data2_in), .imm_in(imm_in),
        .Rd_in(Rd_in), .shift_type_in(shift_type_in), .shift_amt_in(shift_amt_in),
        .set_flags_in(set_flags_in), .reg_write_en_in(reg_write_en_in),
        .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .mem_to_reg_in(mem_to_reg_in), .branch_taken_in(branch_taken_in),
        .alu_src_in(alu_src_in), .alu_op_in(alu_op_in), .alu_invert_rm_in(alu_invert_rm_in),
        .branch_target_addr_in(branch_target_addr_in), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .Rd_out(Rd_out), .pc_out(pc_out),
        .branch_target_addr_out(branch_target_addr_out), .reg_write_en_out(reg_write_en_out),
        .mem_read_en_out(mem_read_en_out), .mem_write_en_out(mem_write_en_out),
        .mem_to_reg_out(mem_to_reg_out), .branch_taken_out(branch_taken_out),
        .flags_out(flags_out), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        pc_in = 32'd0; read_data1_in = 32'd0; read_data2_in = 32'd0;
        branch_target_addr_in = 32'd0; opcode_in = 5'd0; shift_amt_in = 5'd0;
        cond_in = 4'hE; Rd_in = 4'd0; alu_op_in = 4'd0; imm_in = 11'd0;
        shift_type_in = 2'd0; set_flags_in = 1'b0; reg_write_en_in = 1'b0;
        mem_read_en_in = 1'b0; mem_write_en_in = 1'b0; mem_to_reg_in = 1'b0;
        branch_taken_in = 1'b0; alu_src_in = 1'b0; alu_invert_rm_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", alu_result_out, 32'd0);
        chk("rst_flags", flags_out, 32'd0);
        chk("rst_stall", stall_out, 32'd0);
        chk("rst_we", reg_write_en_out, 32'd0);
        reset = 1'b1;

        // ADD imm 5 + 7, S=0
        clear_in(); alu_op_in = 4'h3; alu_src_in = 1'b1; imm_in = 11'd5; read_data1_in = 32'd7;
        reg_write_en_in = 1'b1; Rd_in = 4'd2; pc_in = 32'h100; branch_target_addr_in = 32'h1234;
        tick();
        chk("add_result", alu_result_out, 32'd12);
        chk("add_flags", flags_out, 32'h0);
        chk("add_rd", Rd_out, 32'd2);
        chk("add_we", reg_write_en_out, 32'd1);
        chk("add_pc", pc_out, 32'h100);
        chk("add_bt", branch_target_addr_out, 32'h1234);

        // SUBS 3-3
        clear_in(); alu_op_in = 4'h4; read_data1_in = 32'd3; read_data2_in = 32'd3;
        set_flags_in = 1'b1; reg_write_en_in = 1'b1;
        tick();
        chk("subs_result", alu_result_out, 32'd0);
        chk("subs_flags", flags_out, 32'h6);
        chk("subs_store", store_data_out, 32'd3);

        // ADDEQ passes, ADDNE fails
        clear_in(); cond_in = 4'h0; alu_op_in = 4'h3; alu_src_in = 1'b1; imm_in = 11'd1;
        read_data1_in = 32'd1; reg_write_en_in = 1'b1;
        tick();
        chk("addeq_result", alu_result_out, 32'd2);
        chk("addeq_we", reg_write_en_out, 32'd1);
        cond_in = 4'h1;
        tick();
        chk("addne_we", reg_write_en_out, 32'd0);
        chk("addne_flags", flags_out, 32'h6);

        // ADDS overflow
        clear_in(); alu_op_in = 4'h3; alu_src_in = 1'b1; imm_in = 11'd1;
        read_data1_in = 32'h7FFF_FFFF; set_flags_in = 1'b1;
        tick();
        chk("adds_ovf_result", alu_result_out, 32'h8000_0000);
        chk("adds_ovf_flags", flags_out, 32'h9);

        // MOV ASR #4
        clear_in(); alu_op_in = 4'h8; read_data2_in = 32'h8000_0000; shift_type_in = 2'b10; shift_amt_in = 5'd4;
        tick();
        chk("mov_asr", alu_result_out, 32'hF800_0000);
        chk("mov_asr_flags", flags_out, 32'h9);

        // BIC as AND with inverted Rm
        clear_in(); alu_op_in = 4'h0; read_data1_in = 32'hFF; read_data2_in = 32'h0F; alu_invert_rm_in = 1'b1;
        tick();
        chk("bic_result", alu_result_out, 32'hF0);

        // CMP 5,7
        clear_in(); alu_op_in = 4'h9; read_data1_in = 32'd5; read_data2_in = 32'd7; reg_write_en_in = 1'b1;
        tick();
        chk("cmp_we", reg_write_en_out, 32'd0);
        chk("cmp_flags", flags_out, 32'h8);

        // MOVS LSL #1: carry from shifter, V kept
        clear_in(); alu_op_in = 4'h8; read_data2_in = 32'h8000_0001; shift_amt_in = 5'd1; set_flags_in = 1'b1;
        tick();
        chk("movs_lsl_result", alu_result_out, 32'd2);
        chk("movs_lsl_flags", flags_out, 32'h2);

        // MOV ROR #1
        clear_in(); alu_op_in = 4'h8; read_data2_in = 32'd1; shift_type_in = 2'b11; shift_amt_in = 5'd1;
        tick();
        chk("mov_ror", alu_result_out, 32'h8000_0000);

        // Condition 1111 never executes
        clear_in(); cond_in = 4'hF; alu_op_in = 4'h3; read_data1_in = 32'd1;
        reg_write_en_in = 1'b1; mem_write_en_in = 1'b1;
        tick();
        chk("nv_we", reg_write_en_out, 32'd0);
        chk("nv_mw", mem_write_en_out, 32'd0);

        // Reserved op with S set: result 0, flags untouched
        clear_in(); alu_op_in = 4'hD; set_flags_in = 1'b1; read_data1_in = 32'd5; read_data2_in = 32'd6;
        tick();
        chk("rsvd_result", alu_result_out, 32'd0);
        chk("rsvd_flags", flags_out, 32'h2);

        // MOVS LSR #0 of 0: identity, carry keeps C
        clear_in(); alu_op_in = 4'h8; shift_type_in = 2'b01; set_flags_in = 1'b1;
        tick();
        chk("movs_lsr0_flags", flags_out, 32'h6);

        // MUL 1234 * 5678
        clear_in(); opcode_in = 5'b10000; read_data1_in = 32'd1234; read_data2_in = 32'd5678;
        Rd_in = 4'd5; reg_write_en_in = 1'b1; set_flags_in = 1'b1; pc_in = 32'h200;
        #1;
        chk("mul1_accept_stall", stall_out, 32'd1);
        stall_cnt = 0; bubbles = 0; guard = 0;
        while (stall_out && guard < 40) begin
            stall_cnt++; guard++;
            tick();
            if (!reg_write_en_out && !mem_write_en_out) bubbles++;
        end
        chk("mul1_stall_cycles", stall_cnt, 32'd32);
        chk("mul1_bubbles", bubbles, 32'd32);
        tick();
        chk("mul1_result", alu_result_out, 32'd7006652);
        chk("mul1_rd", Rd_out, 32'd5);
        chk("mul1_we", reg_write_en_out, 32'd1);
        chk("mul1_pc", pc_out, 32'h200);
        chk("mul1_flags", flags_out, 32'h2);

        // Second MUL directly following
        read_data1_in = 32'd3; read_data2_in = 32'd4; Rd_in = 4'd6;
        #1;
        chk("mul2_accept_stall", stall_out, 32'd1);
        stall_cnt = 0; guard = 0;
        while (stall_out && guard < 40) begin
            stall_cnt++; guard++;
            tick();
        end
        chk("mul2_stall_cycles", stall_cnt, 32'd32);
        tick();
        chk("mul2_result", alu_result_out, 32'd12);
        chk("mul2_rd", Rd_out, 32'd6);

        // Reset in BUSY count 10 aborts the MUL
        read_data1_in = 32'd1234; read_data2_in = 32'd5678; Rd_in = 4'd7;
        tick();
        repeat (10) tick();
        chk("mul3_busy_stall", stall_out, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_result", alu_result_out, 32'd0);
        chk("abort_flags", flags_out, 32'd0);
        chk("abort_stall", stall_out, 32'd0);
        chk("abort_rd", Rd_out, 32'd0);
        chk("abort_pc", pc_out, 32'd0);
        clear_in(); cond_in = 4'hF; alu_op_in = 4'hD;
        tick();
        reset = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (stall_out || reg_write_en_out || alu_result_out == 32'd7006652) bad_cycles++;
        end
        chk("abort_no_result", bad_cycles, 32'd0);
        chk("abort_final_result", alu_result_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
